// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit.
// No timing of its own: constants only.
// No handshake: constants only.
package md_pkg;

  // Operation select encodings
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  // HI/LO select for mthi/mtlo writes and mfhi/mflo reads
  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  // Width of the busy-cycle counter; cycle parameters must fit in it
  localparam int CNT_W = 4;

  // True for the divide operations
  function automatic logic is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath on the latched operands.
// Zero latency: results follow op/a/b within the same cycle.
// No handshake: the caller decides when to sample hi_res/lo_res.
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;

  // One multiplier and one divider shared by the signed and unsigned forms.
  // Signed divide works on magnitudes and fixes signs afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    signed_op   = (op == MD_MULT) || (op == MD_DIV);
    div_by_zero = is_div(op) && (b == 32'd0);

    a_ext = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;

    a_mag = (signed_op && a[31]) ? (~a + 32'd1) : a;
    b_mag = (signed_op && b[31]) ? (~b + 32'd1) : b;
    dvd   = a_mag;
    // Divisor forced nonzero so the datapath never divides by zero; the
    // result is discarded by the top level in that case anyway.
    dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo   = dvd / dvs;
    rem   = dvd % dvs;

    if (signed_op && (a[31] ^ b[31])) begin
      quo = ~quo + 32'd1;
    end
    if (signed_op && a[31]) begin
      rem = ~rem + 32'd1;
    end

    if (is_div(op)) begin
      hi_res = rem;
      lo_res = quo;
    end else begin
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, mthi/mtlo writes and mfhi/mflo read.
// Latency: busy for MULT_CYCLES or DIV_CYCLES edges; result visible when busy falls.
// No backpressure: start and hilo_we are ignored while busy; stall logic holds them.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_by_zero;

  md_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  // The counter is the busy flag: nonzero means an operation is in flight.
  assign busy  = (cnt_q != '0);
  assign rdata = (hilo_sel == HILO_SEL_HI) ? hi_q : lo_q;

  // Launch, countdown, result writeback and mthi/mtlo; start beats hilo_we.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == 1 && !div_by_zero) begin
        hi_d = hi_res;
        lo_d = lo_res;
      end
    end else if (start) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      cnt_d = is_div(op) ? DIV_N : MULT_N;
    end else if (hilo_we) begin
      if (hilo_sel == HILO_SEL_HI) begin
        hi_d = wdata;
      end else begin
        lo_d = wdata;
      end
    end
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;

  int compared;
  int mismatched;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .wdata    (wdata),
    .busy     (busy),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read HI and LO through the combinational rdata mux.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hilo_sel = 1'b1;
    #1;
    hi = rdata;
    hilo_sel = 1'b0;
    #1;
    lo = rdata;
  endtask

  // Pulse start for one edge, then count busy cycles (bounded) and check HI/LO.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int n_exp,
                        input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    logic [31:0] hi;
    logic [31:0] lo;
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'h5A5A_5A5A;
    b = 32'hA5A5_A5A5;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    compared++;
    if (n !== n_exp) begin
      mismatched++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, n_exp);
    end
    read_hilo(hi, lo);
    compared++;
    if (hi !== hi_exp) begin
      mismatched++;
      $display("FAIL %s HI: got %08h expected %08h", name, hi, hi_exp);
    end
    compared++;
    if (lo !== lo_exp) begin
      mismatched++;
      $display("FAIL %s LO: got %08h expected %08h", name, lo, lo_exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi;
    logic [31:0] lo;
    clr_n = 1'b0;
    start = 1'b0; op = 2'd0; a = '0; b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; wdata = '0;
    repeat (2) tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset busy: got %b expected 0", busy);
    end
    read_hilo(hi, lo);
    compared++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      mismatched++;
      $display("FAIL reset hilo: got %08h/%08h expected 0/0", hi, lo);
    end
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    logic [31:0] lo;
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // Back-to-back: MULTU starts in the first cycle busy is low.
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    // Old LO must be visible while a new operation is running.
    op = 2'd0; a = 32'd7; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    hilo_sel = 1'b0;
    #1;
    lo = rdata;
    compared++;
    if (lo !== 32'h0000_0001) begin
      mismatched++;
      $display("FAIL rdata_during_busy: got %08h expected 00000001", lo);
    end
    while (busy) tick();
  endtask

  task automatic test_div();
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 2'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("div_negdivisor", 2'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
  endtask

  task automatic test_div_zero_and_ignored();
    int n;
    logic [31:0] hi;
    logic [31:0] lo;
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h1234;
    tick();
    hilo_sel = 1'b0; wdata = 32'h5678;
    tick();
    hilo_we = 1'b0;
    op = 2'd3; a = 32'd100; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin
        op = 2'd0; a = 32'd9; b = 32'd9; start = 1'b1;
      end else if (n == 5) begin
        start = 1'b0;
        hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hBEEF;
      end else begin
        start = 1'b0;
        hilo_we = 1'b0;
      end
      tick();
    end
    start = 1'b0; hilo_we = 1'b0;
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL divzero busy_cycles: got %0d expected 10", n);
    end
    read_hilo(hi, lo);
    compared++;
    if (hi !== 32'h1234) begin
      mismatched++;
      $display("FAIL divzero HI: got %08h expected 00001234", hi);
    end
    compared++;
    if (lo !== 32'h5678) begin
      mismatched++;
      $display("FAIL divzero LO: got %08h expected 00005678", lo);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi;
    logic [31:0] lo;
    op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clr_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset busy: got %b expected 0", busy);
    end
    read_hilo(hi, lo);
    compared++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      mismatched++;
      $display("FAIL async_reset hilo: got %08h/%08h expected 0/0", hi, lo);
    end
    tick();
    clr_n = 1'b1;
    tick();
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hABCD;
    tick();
    hilo_we = 1'b0;
    read_hilo(hi, lo);
    compared++;
    if (hi !== 32'hABCD || lo !== 32'h0) begin
      mismatched++;
      $display("FAIL mthi_after_reset: got %08h/%08h expected 0000abcd/00000000", hi, lo);
    end
  endtask

  task automatic test_start_beats_write();
    int n;
    logic [31:0] hi;
    logic [31:0] lo;
    op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hilo_we = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    compared++;
    if (n !== 5) begin
      mismatched++;
      $display("FAIL start_vs_we busy_cycles: got %0d expected 5", n);
    end
    read_hilo(hi, lo);
    compared++;
    if (lo !== 32'd6) begin
      mismatched++;
      $display("FAIL start_vs_we LO: got %08h expected 00000006", lo);
    end
    compared++;
    if (hi !== 32'd0) begin
      mismatched++;
      $display("FAIL start_vs_we HI: got %08h expected 00000000", hi);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero_and_ignored();
    test_reset_mid_op();
    test_start_beats_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
